expansion_scheduler: RTL and testbench
======================================

EXPANSION_SCHEDULER -- requirements
Module: expansion_scheduler

Interface
REQ-001 Parameter WIDTH, default 8, expansion chain bit count.
REQ-002 Parameter REFRESH, default 13500, clk cycles between automatic transfers; 0 disables automatic refresh.
REQ-003 Parameter TIMEOUT, default 4096, maximum clk cycles allowed in WAIT before the transfer is aborted.
REQ-004 clk  input  1  system clock; all logic is on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 req0/req1  input  1  write request from requester 0/1, held high until acked.
REQ-007 mask0/mask1  input  WIDTH  bit-select for the requester's write.
REQ-008 data0/data1  input  WIDTH  write values for the requester.
REQ-009 ack0/ack1  output  1  one-cycle accept pulse to requester 0/1.
REQ-010 out_image  output  WIDTH  current output image.
REQ-011 in_image  output  WIDTH  last captured input image.
REQ-012 in_changed  output  WIDTH  bits of in_image that differ from the previous capture.
REQ-013 in_valid  output  1  one-cycle pulse when in_image and in_changed update.
REQ-014 err  output  1  sticky transfer-timeout flag.
REQ-015 xfer_start  output  1  one-cycle start pulse to the shift-register engine.
REQ-016 xfer_dout  output  WIDTH  image presented to the engine, stable from START until the next START.
REQ-017 xfer_busy  input  1  engine busy.
REQ-018 xfer_done  input  1  one-cycle pulse when the engine completes a transfer.
REQ-019 xfer_din  input  WIDTH  engine input capture, valid in the cycle xfer_done is high.

Function
REQ-020 Arbiter: at most one request is accepted per cycle, in any FSM state.
REQ-021 Arbiter: if exactly one req is high, that requester is accepted.
REQ-022 Arbiter: if both reqs are high, the requester not granted last is accepted (round-robin).
REQ-023 Arbiter: ackN is asserted in the cycle after acceptance, for exactly one cycle.
REQ-024 Arbiter: no new acceptance for requester N occurs in the cycle its ackN is high, so a held req is not double-accepted.
REQ-025 Accepted write: out_image <= (out_image & ~maskN) | (dataN & maskN), visible the next cycle; dirty <= 1.
REQ-026 FSM states are IDLE, START, WAIT and CAPTURE.
REQ-027 IDLE -> START when (dirty or refresh_pend) and xfer_busy==0; otherwise IDLE holds.
REQ-028 START: xfer_start=1 for this cycle only and xfer_dout <= out_image as it stands before any same-cycle write.
REQ-029 START: dirty <= 0 unless a write is accepted in this cycle; refresh_pend <= 0; refresh counter <= 0; state -> WAIT.
REQ-030 WAIT: on xfer_done -> CAPTURE, latching xfer_din.
REQ-031 WAIT: if TIMEOUT cycles elapse without xfer_done, err <= 1 and state -> IDLE; dirty <= 1 so the transfer retries.
REQ-032 CAPTURE: in_changed <= latched_din ^ in_image and in_image <= latched_din.
REQ-033 CAPTURE: in_valid=1 for this cycle only; state -> IDLE.
REQ-034 Refresh counter increments every cycle outside START and saturates at REFRESH-1; reaching REFRESH-1 sets refresh_pend.
REQ-035 Writes accepted during WAIT or CAPTURE update out_image without affecting the transfer in flight; they set dirty, which causes a follow-up transfer.
REQ-036 xfer_done outside WAIT is ignored.
REQ-037 Minimum spacing between xfer_start pulses is 4 cycles.

Reset
REQ-038 On rst: state=IDLE, out_image=0, xfer_dout=0, in_image=0, in_changed=0, in_valid=0, ack0=ack1=0, xfer_start=0, err=0.
REQ-039 On rst: refresh counter=0, refresh_pend=0, last-grant=requester 1 (so requester 0 wins first), dirty=1 (the first transfer pushes the zero image).
REQ-040 rst asserted mid-transfer returns to IDLE immediately; a later xfer_done is ignored; err clears only on rst.

Verification
REQ-041 Release rst, xfer_busy=0, engine returns done 3 cycles after start with xfer_din=0xA5 -> xfer_start 1 cycle after release with xfer_dout=0x00; then in_image=0xA5, in_changed=0xA5, in_valid pulse.
REQ-042 req0 and req1 high together with mask0=0x0F/data0=0x05 and mask1=0xF0/data1=0x30 -> ack0 first, ack1 next free slot; out_image=0x35; exactly one follow-up transfer with xfer_dout=0x35.
REQ-043 req1 written with mask=0xFF/data=0x81 during WAIT -> the in-flight xfer_dout is unchanged; a second transfer after CAPTURE carries 0x81.
REQ-044 REFRESH=20, no writes, done returned promptly -> xfer_start recurs every 20 cycles; a repeated xfer_din=0x5A yields in_changed=0x00.
REQ-045 xfer_done withheld, TIMEOUT=16 -> err=1 after 16 WAIT cycles and a retry xfer_start follows; rst clears err.
REQ-046 rst asserted in WAIT, then xfer_done pulsed -> no in_valid and all outputs remain at reset values.

Source files
------------

// File: rtl/expansion_scheduler.sv
// Schedules shift-register expansion transfers: arbitrates two writers into the
// output image, launches transfers on change or periodic refresh, and captures inputs.
module expansion_scheduler #(
    parameter int WIDTH   = 8,
    parameter int REFRESH = 13500,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] mask0,
    input  logic [WIDTH-1:0] mask1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] out_image,
    output logic [WIDTH-1:0] in_image,
    output logic [WIDTH-1:0] in_changed,
    output logic             in_valid,
    output logic             err,
    output logic             xfer_start,
    output logic [WIDTH-1:0] xfer_dout,
    input  logic             xfer_busy,
    input  logic             xfer_done,
    input  logic [WIDTH-1:0] xfer_din
);

    typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;

    localparam int RCW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RCW-1:0] REFRESH_LAST  = (REFRESH > 0) ? RCW'(REFRESH - 1) : '0;
    localparam logic [RCW-1:0] REFRESH_FIRST = (REFRESH > 1) ? RCW'(1) : '0;
    localparam logic [TCW-1:0] TIMEOUT_LAST  = (TIMEOUT > 0) ? TCW'(TIMEOUT - 1) : '0;

    state_t           state, state_next;
    logic             last_grant;
    logic             dirty;
    logic             refresh_pend;
    logic [RCW-1:0]   refresh_cnt, refresh_cnt_next;
    logic [TCW-1:0]   timeout_cnt;
    logic [WIDTH-1:0] latched_din;
    logic             elig0, elig1, accept0, accept1;
    logic             timeout_hit;

    // A requester whose ack is showing is still holding req; exclude it that cycle.
    always_comb begin
        elig0   = req0 & ~ack0;
        elig1   = req1 & ~ack1;
        accept0 = elig0 & (~elig1 | last_grant);
        accept1 = elig1 & (~elig0 | ~last_grant);
    end

    always_comb begin
        state_next  = state;
        xfer_start  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE:    if ((dirty | refresh_pend) & ~xfer_busy) state_next = START;
            START: begin
                xfer_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (xfer_done) begin
                    state_next = CAPTURE;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        refresh_cnt_next = (refresh_cnt == REFRESH_LAST) ? refresh_cnt : refresh_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            out_image    <= '0;
            xfer_dout    <= '0;
            in_image     <= '0;
            in_changed   <= '0;
            in_valid     <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err          <= 1'b0;
            refresh_cnt  <= '0;
            refresh_pend <= 1'b0;
            last_grant   <= 1'b1;
            dirty        <= 1'b1;
            timeout_cnt  <= '0;
            latched_din  <= '0;
        end else begin
            state <= state_next;
            ack0  <= accept0;
            ack1  <= accept1;

            if (accept0) begin
                out_image  <= (out_image & ~mask0) | (data0 & mask0);
                last_grant <= 1'b0;
            end else if (accept1) begin
                out_image  <= (out_image & ~mask1) | (data1 & mask1);
                last_grant <= 1'b1;
            end

            if (accept0 | accept1)  dirty <= 1'b1;
            else if (state == START) dirty <= 1'b0;
            else if (timeout_hit)    dirty <= 1'b1;

            if (state == START) begin
                xfer_dout   <= out_image;
                timeout_cnt <= '0;
            end else if (state == WAIT) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end

            if (timeout_hit) err <= 1'b1;
            if ((state == WAIT) && xfer_done) latched_din <= xfer_din;

            // in_valid is registered so it lines up with the new in_image/in_changed.
            in_valid <= (state == CAPTURE);
            if (state == CAPTURE) begin
                in_changed <= latched_din ^ in_image;
                in_image   <= latched_din;
            end

            // The START cycle counts as cycle zero, so refresh starts recur every REFRESH cycles.
            if (REFRESH == 0) begin
                refresh_cnt  <= '0;
                refresh_pend <= 1'b0;
            end else if (state == START) begin
                refresh_cnt  <= REFRESH_FIRST;
                refresh_pend <= 1'b0;
            end else begin
                refresh_cnt <= refresh_cnt_next;
                if (refresh_cnt_next == REFRESH_LAST) refresh_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_expansion_scheduler.sv
// Directed bench: dut_a has refresh disabled, dut_b uses REFRESH=20 and TIMEOUT=16.
module tb_expansion_scheduler;

    logic       clk;
    logic       rst, req0, req1, xfer_busy;
    logic [7:0] mask0, mask1, data0, data1;
    logic       done_a, done_b;
    logic [7:0] din_a, din_b;

    logic       ack0_a, ack1_a, in_valid_a, err_a, xfer_start_a;
    logic [7:0] out_image_a, in_image_a, in_changed_a, xfer_dout_a;
    logic       ack0_b, ack1_b, in_valid_b, err_b, xfer_start_b;
    logic [7:0] out_image_b, in_image_b, in_changed_b, xfer_dout_b;

    logic       eng_a_en = 1'b1;
    logic       eng_b_en = 1'b1;
    logic [7:0] eng_a_din = 8'hA5;
    logic [7:0] eng_b_din = 8'h5A;
    int         nsa = 0;
    int         nsb = 0;
    int         nsb_base;
    int         checks = 0;
    int         errors = 0;

    expansion_scheduler #(.WIDTH(8), .REFRESH(0), .TIMEOUT(4096)) dut_a (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .mask0(mask0), .mask1(mask1), .data0(data0), .data1(data1),
        .ack0(ack0_a), .ack1(ack1_a), .out_image(out_image_a), .in_image(in_image_a),
        .in_changed(in_changed_a), .in_valid(in_valid_a), .err(err_a),
        .xfer_start(xfer_start_a), .xfer_dout(xfer_dout_a), .xfer_busy(xfer_busy),
        .xfer_done(done_a), .xfer_din(din_a)
    );

    expansion_scheduler #(.WIDTH(8), .REFRESH(20), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .mask0(mask0), .mask1(mask1), .data0(data0), .data1(data1),
        .ack0(ack0_b), .ack1(ack1_b), .out_image(out_image_b), .in_image(in_image_b),
        .in_changed(in_changed_b), .in_valid(in_valid_b), .err(err_b),
        .xfer_start(xfer_start_b), .xfer_dout(xfer_dout_b), .xfer_busy(xfer_busy),
        .xfer_done(done_b), .xfer_din(din_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine models: done pulses in the third cycle after the start cycle.
    initial begin
        done_a = 1'b0;
        din_a  = '0;
        forever begin
            @(negedge clk);
            if (eng_a_en && xfer_start_a === 1'b1) begin
                repeat (3) @(negedge clk);
                din_a  = eng_a_din;
                done_a = 1'b1;
                @(negedge clk);
                done_a = 1'b0;
            end
        end
    end

    initial begin
        done_b = 1'b0;
        din_b  = '0;
        forever begin
            @(negedge clk);
            if (eng_b_en && xfer_start_b === 1'b1) begin
                repeat (3) @(negedge clk);
                din_b  = eng_b_din;
                done_b = 1'b1;
                @(negedge clk);
                done_b = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (xfer_start_a === 1'b1) nsa++;
            if (xfer_start_b === 1'b1) nsb++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; xfer_busy = 1'b0;
        mask0 = '0; mask1 = '0; data0 = '0; data1 = '0;
        tick(3);
        check("rst_out_image", out_image_a, 0);
        check("rst_ack0", ack0_a, 0);
        check("rst_ack1", ack1_a, 0);
        check("rst_xfer_start", xfer_start_a, 0);
        check("rst_xfer_dout", xfer_dout_a, 0);
        check("rst_in_valid", in_valid_a, 0);
        check("rst_err", err_a, 0);
        check("rst_in_image", in_image_a, 0);

        // First transfer pushes the zero image
        rst = 1'b0;
        tick;
        check("first_start", xfer_start_a, 1);
        tick;
        check("first_start_pulse", xfer_start_a, 0);
        check("first_dout", xfer_dout_a, 8'h00);
        tick(4);
        check("first_in_valid", in_valid_a, 1);
        check("first_in_image", in_image_a, 8'hA5);
        check("first_in_changed", in_changed_a, 8'hA5);
        tick;
        check("first_in_valid_pulse", in_valid_a, 0);
        check("first_start_count", nsa, 1);

        // Simultaneous requests: requester 0 wins first
        eng_a_din = 8'h3C;
        mask0 = 8'h0F; data0 = 8'h05; mask1 = 8'hF0; data1 = 8'h30;
        req0 = 1'b1; req1 = 1'b1;
        tick;
        check("rr_ack0", ack0_a, 1);
        check("rr_ack1_low", ack1_a, 0);
        check("rr_out_05", out_image_a, 8'h05);
        req0 = 1'b0;
        tick;
        check("rr_ack0_low", ack0_a, 0);
        check("rr_ack1", ack1_a, 1);
        check("rr_out_35", out_image_a, 8'h35);
        check("rr_followup_start", xfer_start_a, 1);
        req1 = 1'b0;
        tick;
        check("rr_ack1_pulse", ack1_a, 0);
        check("rr_dout", xfer_dout_a, 8'h35);
        tick(4);
        check("rr_in_valid", in_valid_a, 1);
        check("rr_in_image", in_image_a, 8'h3C);
        check("rr_in_changed", in_changed_a, 8'h99);
        tick(4);
        check("rr_one_followup", nsa, 2);

        // Write during WAIT leaves the in-flight image alone
        eng_a_din = 8'h0F;
        mask0 = 8'hFF; data0 = 8'h11; req0 = 1'b1;
        tick;
        check("wait_ack0", ack0_a, 1);
        check("wait_out_11", out_image_a, 8'h11);
        req0 = 1'b0;
        tick;
        check("wait_start", xfer_start_a, 1);
        tick;
        check("wait_dout_11", xfer_dout_a, 8'h11);
        mask1 = 8'hFF; data1 = 8'h81; req1 = 1'b1;
        tick;
        check("wait_ack1", ack1_a, 1);
        check("wait_out_81", out_image_a, 8'h81);
        check("wait_dout_held", xfer_dout_a, 8'h11);
        req1 = 1'b0;
        tick(3);
        check("wait_in_valid", in_valid_a, 1);
        check("wait_in_image", in_image_a, 8'h0F);
        check("wait_in_changed", in_changed_a, 8'h33);
        check("wait_dout_stable", xfer_dout_a, 8'h11);
        tick;
        check("wait_second_start", xfer_start_a, 1);
        tick;
        check("wait_second_dout", xfer_dout_a, 8'h81);
        tick(8);
        check("wait_start_count", nsa, 4);
        check("wait_repeat_changed", in_changed_a, 8'h00);

        // Busy engine holds IDLE, then reset mid-transfer discards the late done
        xfer_busy = 1'b1; rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        check("busy_no_start", xfer_start_a, 0);
        eng_a_din = 8'hC3;
        xfer_busy = 1'b0;
        tick;
        check("busy_release_start", xfer_start_a, 1);
        tick;
        rst = 1'b1; xfer_busy = 1'b1;
        tick;
        rst = 1'b0;
        tick(2);
        check("midrst_no_valid", in_valid_a, 0);
        tick;
        check("midrst_no_valid_late", in_valid_a, 0);
        check("midrst_in_image", in_image_a, 0);
        check("midrst_in_changed", in_changed_a, 0);
        check("midrst_out_image", out_image_a, 0);
        check("midrst_dout", xfer_dout_a, 0);
        check("midrst_err", err_a, 0);
        check("midrst_start", xfer_start_a, 0);
        check("b_rst_out_image", out_image_b, 0);
        check("b_rst_acks", {ack0_b, ack1_b}, 0);
        check("b_rst_in_image", in_image_b, 0);
        check("b_rst_in_valid", in_valid_b, 0);
        check("b_rst_dout", xfer_dout_b, 0);

        // Periodic refresh on dut_b
        nsb_base = nsb;
        xfer_busy = 1'b0;
        tick;
        check("ref_start_0", xfer_start_b, 1);
        tick(5);
        check("ref_in_valid_0", in_valid_b, 1);
        check("ref_in_image_0", in_image_b, 8'h5A);
        check("ref_in_changed_0", in_changed_b, 8'h5A);
        tick(14);
        check("ref_not_early", xfer_start_b, 0);
        tick;
        check("ref_start_20", xfer_start_b, 1);
        tick(5);
        check("ref_in_valid_20", in_valid_b, 1);
        check("ref_in_changed_20", in_changed_b, 8'h00);
        tick(15);
        check("ref_start_40", xfer_start_b, 1);
        check("ref_start_count", nsb - nsb_base, 2);
        eng_b_en = 1'b0;

        // Withheld done times out after 16 WAIT cycles and retries
        tick(16);
        check("to_err_not_yet", err_b, 0);
        tick;
        check("to_err_set", err_b, 1);
        tick;
        check("to_retry_start", xfer_start_b, 1);
        check("to_err_sticky", err_b, 1);
        rst = 1'b1;
        tick;
        check("to_rst_clears_err", err_b, 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
